sprite_line_scheduler: RTL and testbench

Shares one sprite ROM between NUM_SPR on-screen sprites, so each sprite no longer needs its own ROM instance. During horizontal blanking it fetches, one sprite per cycle, the 32-bit ROM row each sprite needs on the next scan line and stores it in shadow registers. It then commits the shadow set to the active registers. During active video it outputs a registered per-pixel paint flag and the winning sprite index to the colour mux.

---
 rtl/sprite_pkg.sv | 21 ++
 rtl/sprite_row_match.sv | 29 ++
 rtl/sprite_line_scheduler.sv | 160 ++++++++++++++++
 tb/tb_sprite_line_scheduler.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and defaults for the sprite line scheduler: FSM states and
// the unpacked per-sprite view of the packed position/enable ports.
package sprite_pkg;

  localparam int SPR_W_DEF = 32;
  localparam int SPR_H_DEF = 16;
  localparam int COORD_W   = 11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    COMMIT = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               en;
  } sprite_t;

endpackage

// File: rtl/sprite_row_match.sv
// Decides whether a sprite intersects the line being prefetched and which
// ROM row of that sprite the line needs.
module sprite_row_match
  import sprite_pkg::*;
#(
  parameter int SPR_H = SPR_H_DEF
) (
  input  logic [COORD_W-1:0] next_y,
  input  logic [COORD_W-1:0] spr_y,
  input  logic               spr_en,
  output logic               hit,
  output logic [3:0]         row
);

  logic [11:0] ny_s;
  logic [11:0] sy_s;
  logic [11:0] sy_end_s;
  logic [11:0] diff_s;

  // Widened by one bit so a sprite starting near 2047 never wraps to the top.
  assign ny_s     = {1'b0, next_y};
  assign sy_s     = {1'b0, spr_y};
  assign sy_end_s = sy_s + 12'(SPR_H);
  assign diff_s   = ny_s - sy_s;

  assign hit = spr_en && (ny_s >= sy_s) && (ny_s < sy_end_s);
  assign row = diff_s[3:0];

endmodule

// File: rtl/sprite_line_scheduler.sv
// Prefetches each sprite's next-line ROM row during blanking through one
// shared ROM, then paints from the committed row set during active video.
module sprite_line_scheduler
  import sprite_pkg::*;
#(
  parameter  int NUM_SPR  = 4,
  parameter  int SPR_W    = SPR_W_DEF,
  parameter  int SPR_H    = SPR_H_DEF,
  parameter  int V_ACTIVE = 480,
  localparam int IDW      = $clog2(NUM_SPR)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [10:0]                pix_x,
  input  logic [10:0]                pix_y,
  input  logic                       line_end,
  input  logic [NUM_SPR*11-1:0]      spr_x,
  input  logic [NUM_SPR*11-1:0]      spr_y,
  input  logic [NUM_SPR-1:0]         spr_en,
  output logic [IDW+3:0]             rom_addr,
  input  logic [SPR_W-1:0]           rom_data,
  output logic                       paint,
  output logic [IDW-1:0]             paint_id,
  output logic                       busy
);

  localparam int XW = $clog2(SPR_W);

  sched_state_t       state_q, state_d;
  logic [IDW-1:0]     i_q, i_d;
  logic [10:0]        next_y_q, next_y_d;
  logic [SPR_W-1:0]   shadow_word_q [NUM_SPR];
  logic [SPR_W-1:0]   shadow_word_d [NUM_SPR];
  logic [10:0]        shadow_x_q    [NUM_SPR];
  logic [10:0]        shadow_x_d    [NUM_SPR];
  logic [SPR_W-1:0]   active_word_q [NUM_SPR];
  logic [SPR_W-1:0]   active_word_d [NUM_SPR];
  logic [10:0]        active_x_q    [NUM_SPR];
  logic [10:0]        active_x_d    [NUM_SPR];
  logic               paint_q, paint_d;
  logic [IDW-1:0]     paint_id_q, paint_id_d;
  logic               busy_q, busy_d;

  sprite_t            spr_s [NUM_SPR];
  sprite_t            spr_sel_s;
  logic               hit_s;
  logic [3:0]         row_s;
  logic [IDW+3:0]     rom_addr_s;
  logic [11:0]        dx_s [NUM_SPR];
  logic [NUM_SPR-1:0] cover_s;

  always_comb begin
    for (int k = 0; k < NUM_SPR; k++) begin
      spr_s[k].x  = spr_x[k*11 +: 11];
      spr_s[k].y  = spr_y[k*11 +: 11];
      spr_s[k].en = spr_en[k];
    end
  end

  assign spr_sel_s = spr_s[i_q];

  sprite_row_match #(.SPR_H(SPR_H)) u_row_match (
    .next_y (next_y_q),
    .spr_y  (spr_sel_s.y),
    .spr_en (spr_sel_s.en),
    .hit    (hit_s),
    .row    (row_s)
  );

  always_comb begin
    state_d       = state_q;
    i_d           = i_q;
    next_y_d      = next_y_q;
    shadow_word_d = shadow_word_q;
    shadow_x_d    = shadow_x_q;
    active_word_d = active_word_q;
    active_x_d    = active_x_q;
    rom_addr_s    = '0;
    case (state_q)
      IDLE: begin
        if (line_end) begin
          next_y_d = (pix_y == 11'(V_ACTIVE - 1)) ? 11'd0 : pix_y + 11'd1;
          i_d      = '0;
          state_d  = FETCH;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        rom_addr_s         = hit_s ? {i_q, row_s} : {i_q, 4'b0000};
        shadow_word_d[i_q] = hit_s ? rom_data : '0;
        shadow_x_d[i_q]    = spr_sel_s.x;
        i_d                = i_q + IDW'(1);
        if (i_q == IDW'(NUM_SPR - 1)) begin
          state_d = COMMIT;
        end else begin
          state_d = FETCH;
        end
      end
      COMMIT: begin
        active_word_d = shadow_word_q;
        active_x_d    = shadow_x_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Horizontal hit test per sprite; the descending scan leaves the lowest index.
  always_comb begin
    cover_s    = '0;
    paint_id_d = '0;
    for (int k = NUM_SPR - 1; k >= 0; k--) begin
      dx_s[k]    = {1'b0, pix_x} - {1'b0, active_x_q[k]};
      cover_s[k] = ({1'b0, pix_x} >= {1'b0, active_x_q[k]}) && (dx_s[k] < 12'(SPR_W)) &&
                   active_word_q[k][XW'(SPR_W - 1) - dx_s[k][XW-1:0]];
      if (cover_s[k]) begin
        paint_id_d = IDW'(k);
      end else begin
        paint_id_d = paint_id_d;
      end
    end
    paint_d = |cover_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      i_q        <= '0;
      next_y_q   <= '0;
      paint_q    <= 1'b0;
      paint_id_q <= '0;
      busy_q     <= 1'b0;
      for (int k = 0; k < NUM_SPR; k++) begin
        shadow_word_q[k] <= '0;
        shadow_x_q[k]    <= '0;
        active_word_q[k] <= '0;
        active_x_q[k]    <= '0;
      end
    end else begin
      state_q       <= state_d;
      i_q           <= i_d;
      next_y_q      <= next_y_d;
      paint_q       <= paint_d;
      paint_id_q    <= paint_id_d;
      busy_q        <= busy_d;
      shadow_word_q <= shadow_word_d;
      shadow_x_q    <= shadow_x_d;
      active_word_q <= active_word_d;
      active_x_q    <= active_x_d;
    end
  end

  assign rom_addr = rom_addr_s;
  assign paint    = paint_q;
  assign paint_id = paint_id_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Directed self-checking bench for sprite_line_scheduler with a behavioural
// combinational ROM (4 sprites x 16 rows x 32 bits).
module tb_sprite_line_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] pix_x;
  logic [10:0] pix_y;
  logic        line_end;
  logic [43:0] spr_x;
  logic [43:0] spr_y;
  logic [3:0]  spr_en;
  logic [5:0]  rom_addr;
  logic [31:0] rom_data;
  logic        paint;
  logic [1:0]  paint_id;
  logic        busy;

  logic [31:0] rom [64];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  sprite_line_scheduler #(.NUM_SPR(4), .SPR_W(32), .SPR_H(16), .V_ACTIVE(480)) dut (
    .clk      (clk),
    .rst      (rst),
    .pix_x    (pix_x),
    .pix_y    (pix_y),
    .line_end (line_end),
    .spr_x    (spr_x),
    .spr_y    (spr_y),
    .spr_en   (spr_en),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .paint    (paint),
    .paint_id (paint_id),
    .busy     (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_spr(input int k, input int x, input int y, input logic en);
    spr_x[k*11 +: 11] = 11'(x);
    spr_y[k*11 +: 11] = 11'(y);
    spr_en[k]         = en;
  endtask

  // Pulse line_end on row y and run through FETCH and COMMIT.
  task automatic do_line(input int y);
    pix_y    = 11'(y);
    line_end = 1'b1;
    tick();
    line_end = 1'b0;
    repeat (5) tick();
  endtask

  initial begin
    for (int a = 0; a < 64; a++) rom[a] = 32'h0;
    rst      = 1'b1;
    pix_x    = 11'd0;
    pix_y    = 11'd0;
    line_end = 1'b0;
    spr_x    = 44'd0;
    spr_y    = 44'd0;
    spr_en   = 4'd0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_paint", 32'(paint), 32'd0);
    chk("reset_paint_id", 32'(paint_id), 32'd0);
    chk("reset_rom_addr", 32'(rom_addr), 32'd0);

    // All sprites disabled: five busy cycles, then nothing painted.
    pix_y    = 11'd9;
    line_end = 1'b1;
    tick();
    line_end = 1'b0;
    chk("a_busy0", 32'(busy), 32'd1);
    for (int c = 1; c < 5; c++) begin
      tick();
      chk("a_busy_hold", 32'(busy), 32'd1);
    end
    tick();
    chk("a_busy_fall", 32'(busy), 32'd0);
    pix_y = 11'd10;
    for (int x = 0; x < 2048; x++) begin
      pix_x = 11'(x);
      tick();
      chk("a_no_paint", 32'(paint), 32'd0);
    end

    // Sprite 0 at (100,50), row 0x80000001: only the two edge pixels paint.
    set_spr(0, 100, 50, 1'b1);
    rom[0] = 32'h8000_0001;
    rom[1] = 32'hFFFF_FFFF;
    do_line(49);
    for (int x = 95; x <= 135; x++) begin
      pix_x = 11'(x);
      tick();
      chk("b_paint", 32'(paint), (x == 100 || x == 131) ? 32'd1 : 32'd0);
      chk("b_id", 32'(paint_id), 32'd0);
    end

    // Sprites 0 and 2 overlap fully: sprite 0 wins.
    set_spr(0, 200, 10, 1'b1);
    set_spr(2, 200, 10, 1'b1);
    rom[0]  = 32'hFFFF_FFFF;
    rom[32] = 32'hFFFF_FFFF;
    do_line(9);
    for (int x = 198; x <= 233; x++) begin
      pix_x = 11'(x);
      tick();
      chk("c_paint", 32'(paint), (x >= 200 && x <= 231) ? 32'd1 : 32'd0);
      chk("c_id", 32'(paint_id), 32'd0);
    end

    // Last active line wraps to line 0; sprite 1 row 0 fetched from {1,0}.
    spr_en = 4'd0;
    set_spr(1, 300, 0, 1'b1);
    rom[16] = 32'hF000_0000;
    rom[17] = 32'h0000_000F;
    pix_y    = 11'd479;
    line_end = 1'b1;
    tick();
    line_end = 1'b0;
    chk("d_addr_i0", 32'(rom_addr), 32'd0);
    tick();
    chk("d_addr_i1", 32'(rom_addr), 32'd16);
    repeat (4) tick();
    for (int x = 298; x <= 333; x++) begin
      pix_x = 11'(x);
      tick();
      chk("d_paint", 32'(paint), (x >= 300 && x <= 303) ? 32'd1 : 32'd0);
      chk("d_id", 32'(paint_id), (x >= 300 && x <= 303) ? 32'd1 : 32'd0);
    end

    // Sprite 3 at (2040,2040): row 5 on line 2045, clipped at x=2047.
    spr_en = 4'd0;
    set_spr(3, 2040, 2040, 1'b1);
    rom[53] = 32'hFFFF_FFFF;
    pix_y    = 11'd2044;
    line_end = 1'b1;
    tick();
    line_end = 1'b0;
    repeat (3) tick();
    chk("e_addr_i3", 32'(rom_addr), 32'd53);
    repeat (2) tick();
    for (int x = 2036; x <= 2047; x++) begin
      pix_x = 11'(x);
      tick();
      chk("e_paint", 32'(paint), (x >= 2040) ? 32'd1 : 32'd0);
      chk("e_id", 32'(paint_id), (x >= 2040) ? 32'd3 : 32'd0);
    end
    for (int x = 0; x <= 7; x++) begin
      pix_x = 11'(x);
      tick();
      chk("e_no_wrap_x", 32'(paint), 32'd0);
    end

    // Same sprite on line 5 must not hit through an 11-bit wraparound.
    do_line(4);
    for (int x = 2040; x <= 2047; x++) begin
      pix_x = 11'(x);
      tick();
      chk("e_no_wrap_y", 32'(paint), 32'd0);
    end

    // Second line_end while busy is ignored.
    line_end = 1'b1;
    tick();
    chk("f_busy1", 32'(busy), 32'd1);
    line_end = 1'b0;
    tick();
    chk("f_busy2", 32'(busy), 32'd1);
    line_end = 1'b1;
    tick();
    chk("f_busy3", 32'(busy), 32'd1);
    line_end = 1'b0;
    tick();
    chk("f_busy4", 32'(busy), 32'd1);
    tick();
    chk("f_busy5", 32'(busy), 32'd1);
    tick();
    chk("f_busy_fall", 32'(busy), 32'd0);
    tick();
    chk("f_busy_stay", 32'(busy), 32'd0);

    // Reset during FETCH cycle 2 clears everything until the next COMMIT.
    spr_en = 4'd0;
    set_spr(0, 100, 50, 1'b1);
    rom[0] = 32'h8000_0001;
    do_line(49);
    pix_x = 11'd100;
    tick();
    chk("g_pre_paint", 32'(paint), 32'd1);
    line_end = 1'b1;
    tick();
    line_end = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("g_rst_busy", 32'(busy), 32'd0);
    chk("g_rst_paint", 32'(paint), 32'd0);
    tick();
    chk("g_post_paint", 32'(paint), 32'd0);
    chk("g_post_busy", 32'(busy), 32'd0);
    pix_x = 11'd131;
    tick();
    chk("g_post_paint131", 32'(paint), 32'd0);
    do_line(49);
    pix_x = 11'd100;
    tick();
    chk("g_resume_paint", 32'(paint), 32'd1);
    chk("g_resume_id", 32'(paint_id), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
